// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types for the pipeline hazard controller.
//   - fwd_sel_t   : ALU operand source select (reg file / MEM result / WB result)
//   - pipe_slot_t : tag record of one in-flight instruction (EX, MEM, WB slots)
//   - BUBBLE      : empty slot constant
//   - slot_writes : true when a slot will write a given non-zero register
// -----------------------------------------------------------------------------
package hazard_pkg;

    // Register index width of the slot tags; must equal $clog2(REG_FILE_DEPTH)
    // of any hazard_ctrl instance that uses this package.
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } pipe_slot_t;

    localparam pipe_slot_t BUBBLE = '0;

    // x0 is hard-wired to zero, so a write to it never produces a value.
    function automatic logic slot_writes(input pipe_slot_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Chooses the source of one ALU operand for the instruction in EX.
//   Ports:
//     i_use_valid : EX holds a real instruction
//     i_src       : source register read by that operand
//     i_mem_slot  : tag of the instruction in MEM (youngest producer)
//     i_wb_slot   : tag of the instruction in WB
//     o_sel       : FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module fwd_select
    import hazard_pkg::*;
(
    input  logic                  i_use_valid,
    input  logic [REG_ADDR_W-1:0] i_src,
    input  pipe_slot_t            i_mem_slot,
    input  pipe_slot_t            i_wb_slot,
    output fwd_sel_t              o_sel
);

    // NOTE: o_sel gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        o_sel = FWD_RF;
        if (i_use_valid) begin
            // MEM holds the newer value when both stages write the same rd.
            if (slot_writes(i_mem_slot, i_src)) begin
                o_sel = FWD_MEM;
            end else if (slot_writes(i_wb_slot, i_src)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Execute-stage pipeline sequencer: tracks destination tags of the
//   instructions in EX/MEM/WB, drives operand forwarding selects, inserts
//   one-cycle load-use stalls and flushes wrong-path work on a taken branch.
//   Ports:
//     i_clk, i_reset_n         clock, synchronous active-low reset
//     i_ID_*                   decoded fields of the instruction in ID
//     i_IE_pc_src              EX resolved a taken branch/jump this cycle
//     o_fwd_a_sel/o_fwd_b_sel  operand source: 00 RF, 01 MEM, 10 WB
//     o_stall_IF/o_stall_ID    hold PC and IF/ID
//     o_flush_ID/o_flush_IE    clear IF/ID, clear ID/EX
//     o_stall_count            saturating load-use stall cycles
//     o_flush_count            saturating flush cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int REG_FILE_DEPTH = 32,
    parameter  int CNT_WIDTH      = 16,
    localparam int REG_FILE_ADDR  = $clog2(REG_FILE_DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_ID_valid,
    input  logic [REG_FILE_ADDR-1:0] i_ID_rs1,
    input  logic [REG_FILE_ADDR-1:0] i_ID_rs2,
    input  logic [REG_FILE_ADDR-1:0] i_ID_rd,
    input  logic                     i_ID_reg_write,
    input  logic                     i_ID_mem_read,
    input  logic                     i_IE_pc_src,
    output logic [1:0]               o_fwd_a_sel,
    output logic [1:0]               o_fwd_b_sel,
    output logic                     o_stall_IF,
    output logic                     o_stall_ID,
    output logic                     o_flush_ID,
    output logic                     o_flush_IE,
    output logic [CNT_WIDTH-1:0]     o_stall_count,
    output logic [CNT_WIDTH-1:0]     o_flush_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    pipe_slot_t           r_ex, r_mem, r_wb;
    logic [CNT_WIDTH-1:0] r_stall_count, r_flush_count;

    pipe_slot_t w_id_slot;
    logic       w_load_use;
    logic       w_stall;
    logic       w_flush;
    fwd_sel_t   w_fwd_a, w_fwd_b;

    assign w_id_slot = '{valid:     1'b1,
                         rs1:       i_ID_rs1,
                         rs2:       i_ID_rs2,
                         rd:        i_ID_rd,
                         reg_write: i_ID_reg_write,
                         mem_read:  i_ID_mem_read};

    // A load in EX delivers its data one stage too late for an ID consumer.
    assign w_load_use = i_ID_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) &&
                        ((r_ex.rd == i_ID_rs1) || (r_ex.rd == i_ID_rs2));

    // Everything combinational is masked while reset is asserted so stale
    // pre-reset tags never leak out. A taken branch discards the stalled
    // instruction anyway, so flush wins over stall.
    assign w_flush = i_reset_n && i_IE_pc_src;
    assign w_stall = i_reset_n && w_load_use && !i_IE_pc_src;

    fwd_select u_fwd_a (
        .i_use_valid (i_reset_n && r_ex.valid),
        .i_src       (r_ex.rs1),
        .i_mem_slot  (r_mem),
        .i_wb_slot   (r_wb),
        .o_sel       (w_fwd_a)
    );

    fwd_select u_fwd_b (
        .i_use_valid (i_reset_n && r_ex.valid),
        .i_src       (r_ex.rs2),
        .i_mem_slot  (r_mem),
        .i_wb_slot   (r_wb),
        .o_sel       (w_fwd_b)
    );

    assign o_fwd_a_sel   = w_fwd_a;
    assign o_fwd_b_sel   = w_fwd_b;
    assign o_stall_IF    = w_stall;
    assign o_stall_ID    = w_stall;
    assign o_flush_ID    = w_flush;
    assign o_flush_IE    = w_flush || w_stall;
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

    // NOTE: state uses non-blocking assignments so the WB<=MEM<=EX shift
    // reads every slot's old value, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ex          <= BUBBLE;
            r_mem         <= BUBBLE;
            r_wb          <= BUBBLE;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            // A stalled or flushed ID instruction becomes a bubble in EX.
            r_ex  <= (i_ID_valid && !w_stall && !w_flush) ? w_id_slot : BUBBLE;

            if (w_stall && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_flush && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. A reference model keeps the issued
//   instructions in a queue (newest first) and derives forwarding, stalls,
//   flushes and counters from the hazard rules directly.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_mem_read;
    logic        ie_pc_src;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall_if, stall_id, flush_id, flush_ie;
    logic [15:0] stall_count, flush_count;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_ID_valid     (id_valid),
        .i_ID_rs1       (id_rs1),
        .i_ID_rs2       (id_rs2),
        .i_ID_rd        (id_rd),
        .i_ID_reg_write (id_reg_write),
        .i_ID_mem_read  (id_mem_read),
        .i_IE_pc_src    (ie_pc_src),
        .o_fwd_a_sel    (fwd_a_sel),
        .o_fwd_b_sel    (fwd_b_sel),
        .o_stall_IF     (stall_if),
        .o_stall_ID     (stall_id),
        .o_flush_ID     (flush_id),
        .o_flush_IE     (flush_ie),
        .o_stall_count  (stall_count),
        .o_flush_count  (flush_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        int unsigned rs1, rs2, rd;
        bit          rw, mr;
    } op_t;

    op_t inflight[$];   // [0] = EX, [1] = MEM, [2] = WB
    int  m_stall_cnt;
    int  m_flush_cnt;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    function automatic op_t bubble();
        op_t o;
        o.v = 0; o.rs1 = 0; o.rs2 = 0; o.rd = 0; o.rw = 0; o.mr = 0;
        return o;
    endfunction

    function automatic void model_reset();
        inflight = {};
        repeat (3) inflight.push_back(bubble());
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endfunction

    function automatic bit produces(op_t o, int unsigned r);
        return o.v && o.rw && (o.rd != 0) && (o.rd == r);
    endfunction

    // Nearest older in-flight producer supplies the value: distance 1 is MEM, 2 is WB.
    function automatic int exp_fwd(int unsigned src);
        if (!inflight[0].v) return 0;
        for (int k = 1; k <= 2; k++) begin
            if (produces(inflight[k], src)) return (k == 1) ? 1 : 2;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive ID/branch inputs, compare every output
    // against the model, then advance the model past the coming edge.
    task automatic step(input bit rst, input bit idv,
                        input int unsigned rs1, input int unsigned rs2, input int unsigned rd,
                        input bit rw, input bit mr, input bit pc);
        op_t ex;
        op_t nxt;
        bit  ld_use, e_stall, e_flush;
        int  ea, eb;
        @(negedge clk);
        reset_n      = rst;
        id_valid     = idv;
        id_rs1       = rs1[4:0];
        id_rs2       = rs2[4:0];
        id_rd        = rd[4:0];
        id_reg_write = rw;
        id_mem_read  = mr;
        ie_pc_src    = pc;
        #1;
        ex      = inflight[0];
        ld_use  = idv && ex.v && ex.mr && (ex.rd != 0) && ((ex.rd == rs1) || (ex.rd == rs2));
        e_flush = rst && pc;
        e_stall = rst && ld_use && !pc;
        ea      = rst ? exp_fwd(ex.rs1) : 0;
        eb      = rst ? exp_fwd(ex.rs2) : 0;

        chk("fwd_a",    32'(fwd_a_sel),   32'(ea));
        chk("fwd_b",    32'(fwd_b_sel),   32'(eb));
        chk("stall_IF", 32'(stall_if),    32'(e_stall));
        chk("stall_ID", 32'(stall_id),    32'(e_stall));
        chk("flush_ID", 32'(flush_id),    32'(e_flush));
        chk("flush_IE", 32'(flush_ie),    32'(e_flush || e_stall));
        chk("stall_cnt", 32'(stall_count), 32'(m_stall_cnt));
        chk("flush_cnt", 32'(flush_count), 32'(m_flush_cnt));

        if (!rst) begin
            model_reset();
        end else begin
            nxt = bubble();
            if (idv && !e_stall && !pc) begin
                nxt.v = 1; nxt.rs1 = rs1; nxt.rs2 = rs2; nxt.rd = rd; nxt.rw = rw; nxt.mr = mr;
            end
            inflight.push_front(nxt);
            void'(inflight.pop_back());
            if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (e_flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end
    endtask

    task automatic nop();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; ie_pc_src = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        nop();
        chk("reset_fwd_a",     32'(fwd_a_sel),   0);
        chk("reset_stall_cnt", 32'(stall_count), 0);
        chk("reset_flush_cnt", 32'(flush_count), 0);

        // x0 is never forwarded and never causes a load-use stall
        step(1, 1, 1, 1, 0, 1, 0, 0);      // add x0,x1,x1
        step(1, 1, 0, 0, 3, 1, 0, 0);      // add x3,x0,x0
        nop();
        chk("x0_fwd_a", 32'(fwd_a_sel), 0);
        chk("x0_fwd_b", 32'(fwd_b_sel), 0);
        step(1, 1, 1, 0, 0, 1, 1, 0);      // lw x0
        step(1, 1, 0, 0, 4, 1, 0, 0);      // add x4,x0,x0
        chk("x0_no_stall", 32'(stall_if), 0);

        // Load-use: lw x7 ; add x8,x7,x2
        step(1, 1, 1, 0, 7, 1, 1, 0);
        step(1, 1, 7, 2, 8, 1, 0, 0);
        chk("lu_stall_IF", 32'(stall_if), 1);
        chk("lu_stall_ID", 32'(stall_id), 1);
        chk("lu_flush_IE", 32'(flush_ie), 1);
        step(1, 1, 7, 2, 8, 1, 0, 0);      // held instruction re-presented
        chk("lu_one_cycle", 32'(stall_if),    0);
        chk("lu_stall_cnt", 32'(stall_count), 1);
        nop();

        // EX->MEM and EX->WB forwarding of x5
        step(1, 1, 1, 2, 5, 1, 0, 0);      // add x5,x1,x2
        step(1, 1, 5, 1, 6, 1, 0, 0);      // add x6,x5,x1
        step(1, 1, 5, 3, 7, 1, 0, 0);      // add x7,x5,x3
        chk("fwd_mem_x5", 32'(fwd_a_sel), 1);
        nop();
        chk("fwd_wb_x5", 32'(fwd_a_sel), 2);

        // MEM and WB both write x9: MEM wins
        step(1, 1, 1, 1, 9, 1, 0, 0);
        step(1, 1, 2, 2, 9, 1, 0, 0);
        step(1, 1, 1, 9, 10, 1, 0, 0);     // add x10,x1,x9
        nop();
        chk("mem_wins_b", 32'(fwd_b_sel), 1);

        // Load-use and taken branch together: flush wins
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 7, 1, 1, 0);      // lw x7
        step(1, 1, 7, 2, 8, 1, 0, 1);      // add x8,x7,x2 with pc_src
        chk("fl_flush_ID", 32'(flush_id), 1);
        chk("fl_flush_IE", 32'(flush_ie), 1);
        chk("fl_stall_IF", 32'(stall_if), 0);
        nop();
        chk("fl_flush_cnt", 32'(flush_count), 1);
        chk("fl_stall_cnt", 32'(stall_count), 0);

        // Reset mid-operation with x5 in MEM
        step(1, 1, 1, 2, 5, 1, 0, 0);
        step(1, 1, 5, 5, 6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_low_fwd_a", 32'(fwd_a_sel), 0);
        nop();
        chk("rst_after_fwd_a", 32'(fwd_a_sel), 0);
        chk("rst_after_fwd_b", 32'(fwd_b_sel), 0);

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0);
        end

        // Flush counter saturation
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            step(1, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1, $urandom_range(0, 1) == 1, 1);
        end
        nop();
        chk("sat_flush_cnt", 32'(flush_count), CNT_MAX);
        chk("sat_stall_cnt", 32'(stall_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
